// File: rtl/wb_write_queue.sv
// Register-file write arbiter: in-order writebacks win, long-latency (mult/div) results wait in a small FIFO.
// Define WBQ_BYPASS_EN to let an md result go straight to the write port when the FIFO is empty and no wb wins.
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_reg,
  input  logic [31:0]              wb_data,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [4:0]               md_reg,
  input  logic [31:0]              md_data,
  input  logic [4:0]               qry_regA,
  input  logic [4:0]               qry_regB,
  output logic                     pending_hitA,
  output logic                     pending_hitB,
  output logic                     ctrl_writeEnable,
  output logic [4:0]               ctrl_writeReg,
  output logic [31:0]              data_writeReg,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [4:0]    regMem  [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [AW-1:0] headPtr;
  logic [AW-1:0] tailPtr;
  logic [AW:0]   count;

  logic wbWin;
  logic fifoEmpty;
  logic mdAccept;
  logic mdUseful;
  logic doBypass;
  logic doPush;
  logic doPop;

  assign wbWin     = wb_valid && (wb_reg != 5'd0);
  assign fifoEmpty = (count == '0);
  assign md_ready  = (count < FullCount);
  assign mdAccept  = md_valid && md_ready && !ctrl_reset;
  // Results aimed at register 0 are consumed but never stored.
  assign mdUseful  = mdAccept && (md_reg != 5'd0);
  assign doPop     = !wbWin && !fifoEmpty;
`ifdef WBQ_BYPASS_EN
  assign doBypass  = mdUseful && fifoEmpty && !wbWin;
`else
  assign doBypass  = 1'b0;
`endif
  assign doPush    = mdUseful && !doBypass;
  assign fifo_count = count;

  // Write port registers: wb first, then FIFO head, then the optional bypass.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
    end else if (wbWin) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= wb_reg;
      data_writeReg    <= wb_data;
    end else if (doPop) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= regMem[headPtr];
      data_writeReg    <= dataMem[headPtr];
    end else if (doBypass) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= md_reg;
      data_writeReg    <= md_data;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doPush) tailPtr <= tailPtr + 1'b1;
      if (doPop)  headPtr <= headPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) begin
      regMem[tailPtr]  <= md_reg;
      dataMem[tailPtr] <= md_data;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    logic [AW-1:0] offset;
    logic hitA;
    logic hitB;
    offset = '0;
    hitA   = ctrl_writeEnable && (ctrl_writeReg == qry_regA);
    hitB   = ctrl_writeEnable && (ctrl_writeReg == qry_regB);
    for (int i = 0; i < DEPTH; i++) begin
      offset = AW'(i) - headPtr;
      if ({1'b0, offset} < count) begin
        if (regMem[i] == qry_regA) hitA = 1'b1;
        if (regMem[i] == qry_regB) hitB = 1'b1;
      end
    end
    pending_hitA = hitA && (qry_regA != 5'd0);
    pending_hitB = hitB && (qry_regB != 5'd0);
  end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning long-latency result FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port ctrl_reset  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port wb_valid  in  1  in-order pipeline writeback request this cycle.
REQ-005 SHALL have port wb_reg  in  5  destination register of the pipeline writeback.
REQ-006 SHALL have port wb_data  in  32  pipeline writeback data.
REQ-007 SHALL have port md_valid  in  1  long-latency unit (mult/div) result offered.
REQ-008 SHALL have port md_ready  out  1  queue accepts the md result this cycle.
REQ-009 SHALL have port md_reg  in  5  md result destination register.
REQ-010 SHALL have port md_data  in  32  md result data.
REQ-011 SHALL have port qry_regA  in  5  register-file read-A index for the pending-write check.
REQ-012 SHALL have port qry_regB  in  5  register-file read-B index for the pending-write check.
REQ-013 SHALL have port pending_hitA  out  1  a queued or issued write targets qry_regA.
REQ-014 SHALL have port pending_hitB  out  1  a queued or issued write targets qry_regB.
REQ-015 SHALL have port ctrl_writeEnable  out  1  register-file write strobe.
REQ-016 SHALL have port ctrl_writeReg  out  5  register-file write index.
REQ-017 SHALL have port data_writeReg  out  32  register-file write data.
REQ-018 SHALL have port fifo_count  out  log2(DEPTH)+1  occupied FIFO entries.

Function
REQ-019 SHALL register ctrl_writeEnable/ctrl_writeReg/data_writeReg; a source selected in cycle N appears on them in cycle N+1 only.
REQ-020 SHALL give wb priority: wb_valid=1 with wb_reg!=0 in cycle N loads the output registers with wb_reg/wb_data, ctrl_writeEnable=1 in N+1.
REQ-021 SHALL drive ctrl_writeEnable=0 in N+1 when the cycle-N winner has no valid write (no wb, FIFO empty, no bypass).
REQ-022 SHALL assert md_ready combinationally iff fifo_count<DEPTH; transfer occurs when md_valid&md_ready at a clock edge.
REQ-023 SHALL push an accepted md result with md_reg!=0 into the FIFO tail; accepted results to register 0 are discarded (not queued).
REQ-024 SHALL pop the FIFO head into the output registers in any cycle where wb_valid=0 (or wb_reg=0) and FIFO non-empty; FIFO order preserved.
REQ-025 SHALL allow same-edge push and pop; fifo_count unchanged then; head/tail pointers wrap modulo DEPTH.
REQ-026 SHALL never push when full (md_ready=0), never pop when empty; full-and-popping still reports md_ready=0 that cycle.
REQ-027 SHALL assert pending_hitX combinationally when qry_regX!=0 and equals the reg field of any valid FIFO entry or of the output registers while ctrl_writeEnable=1; qry_regX=0 gives 0.
REQ-028 SHALL keep md results delayed, never dropped, while wb_valid is continuously high; md_ready falls once FIFO fills.

Reset
REQ-029 SHALL, on ctrl_reset=1 at any time, asynchronously clear ctrl_writeEnable, ctrl_writeReg, data_writeReg, pointers and fifo_count to 0; queued entries are lost.
REQ-030 SHALL, while ctrl_reset=1, hold md_ready=1 (FIFO empty) but accept no transfers; pending_hitA/B=0.
REQ-031 SHALL resume normal operation on the first rising clock edge after ctrl_reset deasserts.

Configuration
REQ-032 SHALL support macro WBQ_BYPASS_EN: defined -> md result accepted in cycle N with FIFO empty and no wb winner goes directly to the output registers (visible N+1, FIFO untouched); undefined -> every md result passes through the FIFO (earliest visibility N+2).

Verification
REQ-033 SHALL cover: wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF cycle N -> ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF in N+1 only.
REQ-034 SHALL cover: wb_valid high 6 cycles, md offers regs 1..6 every cycle, DEPTH=4 -> md_ready=0 after 4 accepts, fifo_count=4, then regs 1..4 written in order once wb_valid drops.
REQ-035 SHALL cover: md result reg 7 with idle pipeline, FIFO empty -> write visible N+1 with WBQ_BYPASS_EN, N+2 without.
REQ-036 SHALL cover: wb_reg=0 and md_reg=0 requests -> no write strobe, fifo_count stays 0, md_ready=1.
REQ-037 SHALL cover: FIFO holds reg 9, qry_regA=9, qry_regB=0 -> pending_hitA=1, pending_hitB=0; hitA clears after the reg-9 write cycle.
REQ-038 SHALL cover: ctrl_reset asserted mid-cycle with fifo_count=3 -> outputs and fifo_count 0 immediately, no stale writes after release.
